// File: rtl/matrix_strip_rx_pkg.sv
// Shared types and constants for the LED-strip matrix receiver.
// Snake unmapping and bitmap reversal helpers live here so the top stays readable.
package matrix_strip_rx_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    PIX  = 1'b1
  } state_t;

  localparam logic [2:0] HDR_OK      = 3'b111;
  localparam int         START_ZEROS = 32;
  localparam int         WORD_W      = 32;

  // Even rows arrive right-to-left on the snake, odd rows left-to-right.
  function automatic logic [5:0] snake_map(input logic [5:0] p);
    return p[3] ? p : {p[5:3], ~p[2:0]};
  endfunction

  // Staging bit 0 is the first display pixel, which is image[63].
  function automatic logic [63:0] bit_rev64(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      r[63-k] = v[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/strip_edge_sync.sv
// Brings the asynchronous strip clock/data into clk_sys and flags one
// bit strobe per rising strip_clk edge.
module strip_edge_sync
  import matrix_strip_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic strip_clk,
  input  logic strip_data,
  output logic bit_stb,
  output logic bit_val
);

  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_d;
  logic r_dat_s1;
  logic r_dat_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_d  <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= strip_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= strip_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Data has the same synchronizer depth as the clock, so it stays aligned with the edge.
  assign bit_stb = r_clk_s2 & ~r_clk_d;
  assign bit_val = r_dat_s2;

endmodule

// File: rtl/matrix_strip_rx.sv
// Decodes an APA102-style serial LED stream into per-pixel fields and a
// 64-bit lit/unlit bitmap of the 8x8 snake-wired matrix.
module matrix_strip_rx
  import matrix_strip_rx_pkg::*;
#(
  parameter int          NUM_PIXELS = 64,
  parameter logic [31:0] FG_WORD    = 32'hF0000F00,
  parameter int          TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strip_clk,
  input  logic        strip_data,
  output logic        pix_valid,
  output logic [5:0]  pix_index,
  output logic [4:0]  pix_bright,
  output logic [7:0]  pix_b,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_r,
  output logic        frame_done,
  output logic        frame_err,
  output logic [63:0] image
);

  localparam int                IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LD = IDLE_W'(TIMEOUT);
  localparam logic [5:0]        ZC_MAX  = 6'(START_ZEROS);
  localparam logic [5:0]        LAST_PX = 6'(NUM_PIXELS - 1);

  logic w_bit_stb;
  logic w_bit_val;

  strip_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .strip_clk  (strip_clk),
    .strip_data (strip_data),
    .bit_stb    (w_bit_stb),
    .bit_val    (w_bit_val)
  );

  state_t              r_state,   w_state_nxt;
  logic [5:0]          r_zcnt,    w_zcnt_nxt;
  logic [4:0]          r_bcnt,    w_bcnt_nxt;
  logic [WORD_W-2:0]   r_shreg,   w_shreg_nxt;
  logic [5:0]          r_pcnt,    w_pcnt_nxt;
  logic [IDLE_W-1:0]   r_idle,    w_idle_nxt;
  logic [63:0]         r_stage,   w_stage_nxt;
  logic                r_pv,      w_pv_nxt;
  logic [5:0]          r_idx,     w_idx_nxt;
  logic [4:0]          r_bright,  w_bright_nxt;
  logic [7:0]          r_b,       w_b_nxt;
  logic [7:0]          r_g,       w_g_nxt;
  logic [7:0]          r_r,       w_r_nxt;
  logic                r_fd,      w_fd_nxt;
  logic                r_fe,      w_fe_nxt;
  logic [63:0]         r_image,   w_image_nxt;
  logic [WORD_W-1:0]   w_word;

  // The last bit completes the word combinationally so it can be judged in its sample cycle.
  assign w_word = {r_shreg, w_bit_val};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= HUNT;
      r_zcnt   <= '0;
      r_bcnt   <= '0;
      r_shreg  <= '0;
      r_pcnt   <= '0;
      r_idle   <= '0;
      r_stage  <= '0;
      r_pv     <= 1'b0;
      r_idx    <= '0;
      r_bright <= '0;
      r_b      <= '0;
      r_g      <= '0;
      r_r      <= '0;
      r_fd     <= 1'b0;
      r_fe     <= 1'b0;
      r_image  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_zcnt   <= w_zcnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_shreg  <= w_shreg_nxt;
      r_pcnt   <= w_pcnt_nxt;
      r_idle   <= w_idle_nxt;
      r_stage  <= w_stage_nxt;
      r_pv     <= w_pv_nxt;
      r_idx    <= w_idx_nxt;
      r_bright <= w_bright_nxt;
      r_b      <= w_b_nxt;
      r_g      <= w_g_nxt;
      r_r      <= w_r_nxt;
      r_fd     <= w_fd_nxt;
      r_fe     <= w_fe_nxt;
      r_image  <= w_image_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_zcnt_nxt   = r_zcnt;
    w_bcnt_nxt   = r_bcnt;
    w_shreg_nxt  = r_shreg;
    w_pcnt_nxt   = r_pcnt;
    w_idle_nxt   = r_idle;
    w_stage_nxt  = r_stage;
    w_pv_nxt     = 1'b0;
    w_idx_nxt    = r_idx;
    w_bright_nxt = r_bright;
    w_b_nxt      = r_b;
    w_g_nxt      = r_g;
    w_r_nxt      = r_r;
    w_fd_nxt     = 1'b0;
    w_fe_nxt     = 1'b0;
    w_image_nxt  = r_image;

    unique case (r_state)
      HUNT: begin
        if (w_bit_stb) begin
          if (!w_bit_val) begin
            if (r_zcnt != ZC_MAX) w_zcnt_nxt = r_zcnt + 6'd1;
          end else if (r_zcnt == ZC_MAX) begin
            w_state_nxt = PIX;
            w_zcnt_nxt  = '0;
            w_shreg_nxt = {{(WORD_W-2){1'b0}}, 1'b1};
            w_bcnt_nxt  = 5'd1;
            w_pcnt_nxt  = '0;
            w_idle_nxt  = IDLE_LD;
            w_stage_nxt = '0;
          end else begin
            w_zcnt_nxt = '0;
          end
        end
      end

      PIX: begin
        if (w_bit_stb) begin
          w_shreg_nxt = w_word[WORD_W-2:0];
          w_bcnt_nxt  = r_bcnt + 5'd1;
          w_idle_nxt  = IDLE_LD;
          if (r_bcnt == 5'd31) begin
            if (w_word[31:29] == HDR_OK) begin
              w_pv_nxt     = 1'b1;
              w_idx_nxt    = r_pcnt;
              w_bright_nxt = w_word[28:24];
              w_b_nxt      = w_word[23:16];
              w_g_nxt      = w_word[15:8];
              w_r_nxt      = w_word[7:0];
              w_stage_nxt[snake_map(r_pcnt)] = (w_word == FG_WORD);
              w_pcnt_nxt   = r_pcnt + 6'd1;
              if (r_pcnt == LAST_PX) begin
                w_image_nxt = bit_rev64(w_stage_nxt);
                w_fd_nxt    = 1'b1;
                w_state_nxt = HUNT;
                w_zcnt_nxt  = '0;
              end
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = HUNT;
              w_zcnt_nxt  = '0;
            end
          end
        end else if (r_idle == IDLE_W'(1)) begin
          w_fe_nxt    = 1'b1;
          w_state_nxt = HUNT;
          w_zcnt_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle - IDLE_W'(1);
        end
      end

      default: w_state_nxt = HUNT;
    endcase
  end

  assign pix_valid  = r_pv;
  assign pix_index  = r_idx;
  assign pix_bright = r_bright;
  assign pix_b      = r_b;
  assign pix_g      = r_g;
  assign pix_r      = r_r;
  assign frame_done = r_fd;
  assign frame_err  = r_fe;
  assign image      = r_image;

endmodule

// File: tb/tb_matrix_strip_rx.sv
// Directed bench for matrix_strip_rx: table of whole frames plus hand-written
// timeout and mid-frame reset sequences.
module tb_matrix_strip_rx;

  localparam int          TOUT = 300;
  localparam logic [31:0] FG   = 32'hF0000F00;
  localparam logic [31:0] BG   = 32'hF0070000;
  localparam logic [31:0] BAD  = 32'h70000F00;

  logic        clk;
  logic        reset;
  logic        strip_clk;
  logic        strip_data;
  logic        pix_valid;
  logic [5:0]  pix_index;
  logic [4:0]  pix_bright;
  logic [7:0]  pix_b;
  logic [7:0]  pix_g;
  logic [7:0]  pix_r;
  logic        frame_done;
  logic        frame_err;
  logic [63:0] image;

  matrix_strip_rx #(
    .NUM_PIXELS (64),
    .FG_WORD    (FG),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strip_clk  (strip_clk),
    .strip_data (strip_data),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .pix_bright (pix_bright),
    .pix_b      (pix_b),
    .pix_g      (pix_g),
    .pix_r      (pix_r),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .image      (image)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fg_mask;
    int          bad_idx;
    int          exp_pv;
    int          exp_fd;
    int          exp_fe;
    logic [63:0] exp_img;
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_err = 0;
  int          pv_cnt = 0;
  int          fd_cnt = 0;
  int          fe_cnt = 0;
  int          exp_idx = 0;
  logic [31:0] exp_words[64];
  logic [63:0] prev_img = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    strip_data = b;
    #20 strip_clk = 1'b1;
    #20 strip_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] mask, input int bad, input int n_words,
                            input int part_bits, input int tail_zeros);
    logic [31:0] w;
    exp_idx = 0;
    for (int p = 0; p < 64; p++)
      exp_words[p] = (p == bad) ? BAD : (mask[p] ? FG : BG);
    for (int i = 0; i < 32; i++) send_bit(1'b0);
    for (int p = 0; p < n_words; p++) begin
      w = exp_words[p];
      for (int b = 31; b >= 0; b--) send_bit(w[b]);
    end
    if (part_bits > 0) begin
      w = exp_words[n_words];
      for (int b = 31; b > 31 - part_bits; b--) send_bit(w[b]);
    end
    for (int i = 0; i < tail_zeros; i++) send_bit(1'b0);
  endtask

  task automatic clr_counts();
    pv_cnt = 0;
    fd_cnt = 0;
    fe_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (pix_valid) begin
        pv_cnt++;
        chk("pix_index", 64'(pix_index), 64'(exp_idx));
        chk("pix_bright", 64'(pix_bright), 64'(exp_words[exp_idx % 64][28:24]));
        chk("pix_b", 64'(pix_b), 64'(exp_words[exp_idx % 64][23:16]));
        chk("pix_g", 64'(pix_g), 64'(exp_words[exp_idx % 64][15:8]));
        chk("pix_r", 64'(pix_r), 64'(exp_words[exp_idx % 64][7:0]));
        exp_idx++;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("done_with_err", 64'(frame_err), 64'd0);
        chk("done_on_last_pix", 64'({pix_valid, pix_index}), 64'({1'b1, 6'd63}));
      end
      if (frame_err) fe_cnt++;
      if (image !== prev_img) chk("image_change_at_done", 64'(frame_done), 64'd1);
    end
    prev_img = image;
  end

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, -1, 64, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{64'h0000_0000_0000_0001, -1, 64, 1, 0, 64'h0100_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_0000_0200, -1, 64, 1, 0, 64'h0040_0000_0000_0000};
    vecs[3] = '{64'h0000_0000_0001_0000, -1, 64, 1, 0, 64'h0000_0100_0000_0000};
    vecs[4] = '{64'h0000_0000_0000_0000,  5,  5, 0, 1, 64'h0000_0100_0000_0000};
    vecs[5] = '{64'h8000_0000_0000_0080, -1, 64, 1, 0, 64'h8000_0000_0000_0001};

    reset = 1'b0;
    strip_clk = 1'b0;
    strip_data = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_image", image, 64'd0);
    chk("rst_fields", 64'({pix_index, pix_bright, pix_b, pix_g, pix_r}), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clr_counts();
      send_frame(vecs[v].fg_mask, vecs[v].bad_idx, 64, 0, 40);
      repeat (8) @(negedge clk);
      chk($sformatf("vec%0d_pv_count", v), 64'(pv_cnt), 64'(vecs[v].exp_pv));
      chk($sformatf("vec%0d_done_count", v), 64'(fd_cnt), 64'(vecs[v].exp_fd));
      chk($sformatf("vec%0d_err_count", v), 64'(fe_cnt), 64'(vecs[v].exp_fe));
      chk($sformatf("vec%0d_image", v), image, vecs[v].exp_img);
    end

    // strip clock stalls after pixel 10
    clr_counts();
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, -1, 11, 0, 0);
    repeat (TOUT + 10) @(negedge clk);
    chk("tout_err_count", 64'(fe_cnt), 64'd1);
    chk("tout_pv_count", 64'(pv_cnt), 64'd11);
    chk("tout_done_count", 64'(fd_cnt), 64'd0);
    chk("tout_image_kept", image, 64'h8000_0000_0000_0001);
    clr_counts();
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, -1, 64, 0, 40);
    repeat (8) @(negedge clk);
    chk("after_tout_pv", 64'(pv_cnt), 64'd64);
    chk("after_tout_done", 64'(fd_cnt), 64'd1);
    chk("after_tout_err", 64'(fe_cnt), 64'd0);
    chk("after_tout_image", image, 64'hFFFF_FFFF_FFFF_FFFF);

    // reset in the middle of pixel 30
    clr_counts();
    send_frame(64'h0000_0000_0000_0080, -1, 30, 16, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_outputs", 64'({pix_valid, frame_done, frame_err}), 64'd0);
    chk("midrst_image", image, 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_pv_before", 64'(pv_cnt), 64'd30);
    send_frame(64'h0000_0000_0000_0001, -1, 64, 0, 40);
    repeat (8) @(negedge clk);
    chk("midrst_err_count", 64'(fe_cnt), 64'd0);
    chk("midrst_done_count", 64'(fd_cnt), 64'd1);
    chk("midrst_pv_count", 64'(pv_cnt), 64'd94);
    chk("midrst_image_after", image, 64'h0100_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
